axil_gpio_bank: RTL and testbench

//  Parametrised AXI-lite GPIO bank. Successor to the single 4-bit output register in the MIO subsystem.

---
 rtl/mio_pkg.sv | 35 +++
 rtl/gpio_sync.sv | 34 +++
 rtl/axil_gpio_bank.sv | 216 +++++++++++++++++++++
 tb/tb_axil_gpio_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared definitions for the MIO GPIO bank: register offsets, AXI response codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mio_pkg;

  // Byte offsets within the GPIO register window; decoding uses bits [4:2].
  localparam logic [31:0] GPIO_DATA_OUT_OFS = 32'h00;
  localparam logic [31:0] GPIO_DIR_OFS      = 32'h04;
  localparam logic [31:0] GPIO_DATA_IN_OFS  = 32'h08;
  localparam logic [31:0] GPIO_IRQ_EN_OFS   = 32'h0C;
  localparam logic [31:0] GPIO_IRQ_STAT_OFS = 32'h10;
  localparam logic [31:0] GPIO_EDGE_SEL_OFS = 32'h14;
  localparam logic [31:0] GPIO_WINDOW_BYTES = 32'h18;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_e;

  // True when a window offset falls outside the map or is not word aligned.
  function automatic logic gpio_ofs_bad(input logic [31:0] ofs);
    return (ofs >= GPIO_WINDOW_BYTES) || (ofs[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Pad input synchroniser with one history flop and per-pin edge select.
// Latency: STAGES cycles to o_sync; o_edge is combinational from o_sync and the history flop.
// Backpressure: none, free-running every cycle.
// Ports: clk/rst_n; i_async pad inputs; i_fall_sel 1 = falling edge per pin;
//        o_sync synchronised value; o_edge one-cycle edge pulse per pin.
module gpio_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_async,
  input  logic [W-1:0] i_fall_sel,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_edge
);

  logic [STAGES-1:0][W-1:0] r_chain;
  logic [W-1:0]             r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_hist  <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_hist  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_edge = (o_sync & ~r_hist & ~i_fall_sel) | (~o_sync & r_hist & i_fall_sel);

endmodule

// File: rtl/axil_gpio_bank.sv
// AXI-lite GPIO bank: output data, direction, synchronised inputs, edge-capture status, level irq.
// Latency: read data 1 cycle after arvalid; write applied at accept, bvalid the cycle after.
// Backpressure: one outstanding write and one outstanding read; no new accept until bready/rready.
// Ports: clk, rst_n; AXI-lite slave axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r*;
//        gpio_in (async pads), gpio_out/gpio_oe (from DATA_OUT/DIR), irq (|(IRQ_STAT & IRQ_EN), registered).
module axil_gpio_bank
  import mio_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h1000_0004,
  parameter int          NUM_GPIO    = 8,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         axi_awaddr,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [31:0]         axi_wdata,
  input  logic [3:0]          axi_wstrb,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [31:0]         axi_araddr,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [31:0]         axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  // Bits at or above NUM_GPIO are held at zero in every register.
  localparam logic [31:0] VALID_MASK = (NUM_GPIO >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'h1 << NUM_GPIO) - 32'h1);

  localparam logic [2:0] SEL_DATA_OUT = GPIO_DATA_OUT_OFS[4:2];
  localparam logic [2:0] SEL_DIR      = GPIO_DIR_OFS[4:2];
  localparam logic [2:0] SEL_DATA_IN  = GPIO_DATA_IN_OFS[4:2];
  localparam logic [2:0] SEL_IRQ_EN   = GPIO_IRQ_EN_OFS[4:2];
  localparam logic [2:0] SEL_IRQ_STAT = GPIO_IRQ_STAT_OFS[4:2];
  localparam logic [2:0] SEL_EDGE_SEL = GPIO_EDGE_SEL_OFS[4:2];

  logic [31:0] r_data_out;
  logic [31:0] r_dir;
  logic [31:0] r_irq_en;
  logic [31:0] r_irq_stat;
  logic [31:0] r_edge_sel;
  logic        r_irq;

  w_state_e  r_wstate, w_wstate_nxt;
  r_state_e  r_rstate, w_rstate_nxt;
  axi_resp_e r_bresp, r_rresp;
  logic [31:0] r_rdata;

  logic        w_wr_fire, w_rd_fire;
  logic [31:0] w_wofs, w_rofs;
  logic [2:0]  w_wsel, w_rsel;
  logic        w_wbad, w_rbad, w_wr_ro, w_wr_ok;
  logic [31:0] w_bmask, w_w1c, w_edge32, w_rdata_nxt;
  logic [NUM_GPIO-1:0] w_sync, w_edge;

  // ---------------- input path ----------------
  gpio_sync #(
    .W      (NUM_GPIO),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_async    (gpio_in),
    .i_fall_sel (r_edge_sel[NUM_GPIO-1:0]),
    .o_sync     (w_sync),
    .o_edge     (w_edge)
  );

  assign w_edge32 = 32'(w_edge);

  // ---------------- write channel ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_fire    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        // Address and data are only taken together; either alone waits.
        if (axi_awvalid && axi_wvalid) begin
          w_wr_fire    = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_bready) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  assign axi_awready = w_wr_fire;
  assign axi_wready  = w_wr_fire;
  assign axi_bvalid  = (r_wstate == W_RESP);
  assign axi_bresp   = r_bresp;

  assign w_wofs  = axi_awaddr - MEM_BASE;
  assign w_wsel  = w_wofs[4:2];
  assign w_wbad  = gpio_ofs_bad(w_wofs);
  assign w_wr_ro = (w_wsel == SEL_DATA_IN);
  assign w_wr_ok = w_wr_fire && !w_wbad && !w_wr_ro;
  assign w_bmask = {{8{axi_wstrb[3]}}, {8{axi_wstrb[2]}},
                    {8{axi_wstrb[1]}}, {8{axi_wstrb[0]}}} & VALID_MASK;
  assign w_w1c   = (w_wr_ok && (w_wsel == SEL_IRQ_STAT)) ? (axi_wdata & w_bmask) : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bresp    <= OKAY;
      r_data_out <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_edge_sel <= '0;
    end else begin
      if (w_wr_fire) r_bresp <= (w_wbad || w_wr_ro) ? SLVERR : OKAY;
      if (w_wr_ok) begin
        case (w_wsel)
          SEL_DATA_OUT: r_data_out <= (r_data_out & ~w_bmask) | (axi_wdata & w_bmask);
          SEL_DIR:      r_dir      <= (r_dir      & ~w_bmask) | (axi_wdata & w_bmask);
          SEL_IRQ_EN:   r_irq_en   <= (r_irq_en   & ~w_bmask) | (axi_wdata & w_bmask);
          SEL_EDGE_SEL: r_edge_sel <= (r_edge_sel & ~w_bmask) | (axi_wdata & w_bmask);
          default: ;
        endcase
      end
    end
  end

  // A new edge in the same cycle as a W1C clear leaves the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_edge32;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_fire    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (axi_arvalid) begin
          w_rd_fire    = 1'b1;
          w_rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (axi_rready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  assign w_rofs = axi_araddr - MEM_BASE;
  assign w_rsel = w_rofs[4:2];
  assign w_rbad = gpio_ofs_bad(w_rofs);

  always_comb begin
    w_rdata_nxt = 32'h0;
    if (!w_rbad) begin
      case (w_rsel)
        SEL_DATA_OUT: w_rdata_nxt = r_data_out;
        SEL_DIR:      w_rdata_nxt = r_dir;
        SEL_DATA_IN:  w_rdata_nxt = 32'(w_sync);
        SEL_IRQ_EN:   w_rdata_nxt = r_irq_en;
        SEL_IRQ_STAT: w_rdata_nxt = r_irq_stat;
        SEL_EDGE_SEL: w_rdata_nxt = r_edge_sel;
        default:      w_rdata_nxt = 32'h0;
      endcase
    end
  end

  // rdata is a snapshot at accept and stays put until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_rresp <= OKAY;
    end else if (w_rd_fire) begin
      r_rdata <= w_rdata_nxt;
      r_rresp <= w_rbad ? SLVERR : OKAY;
    end
  end

  assign axi_arready = w_rd_fire;
  assign axi_rvalid  = (r_rstate == R_RESP);
  assign axi_rdata   = r_rdata;
  assign axi_rresp   = r_rresp;

  // ---------------- pads and interrupt ----------------
  assign gpio_out = r_data_out[NUM_GPIO-1:0];
  assign gpio_oe  = r_dir[NUM_GPIO-1:0];
  assign irq      = r_irq;

endmodule

// File: tb/tb_axil_gpio_bank.sv
module tb_axil_gpio_bank;

  localparam logic [31:0] BASE = 32'h1000_0004;
  localparam int N   = 8;
  localparam int S   = 2;
  localparam int LIM = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  axi_awaddr = '0;
  logic         axi_awvalid = 1'b0;
  logic         axi_awready;
  logic [31:0]  axi_wdata = '0;
  logic [3:0]   axi_wstrb = '0;
  logic         axi_wvalid = 1'b0;
  logic         axi_wready;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready = 1'b0;
  logic [31:0]  axi_araddr = '0;
  logic         axi_arvalid = 1'b0;
  logic         axi_arready;
  logic [31:0]  axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rvalid;
  logic         axi_rready = 1'b0;
  logic [N-1:0] gpio_in = '0;
  logic [N-1:0] gpio_out;
  logic [N-1:0] gpio_oe;
  logic         irq;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_wait  = 0;

  logic [31:0] rd;
  logic [1:0]  rsp;

  always #5 clk = ~clk;

  axil_gpio_bank #(
    .MEM_BASE    (BASE),
    .NUM_GPIO    (N),
    .SYNC_STAGES (S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_araddr  (axi_araddr),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    @(negedge clk);
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    #1;
    n = 0;
    while (!(axi_awready && axi_wready) && n < LIM) begin
      @(negedge clk); #1; n++;
    end
    if (!axi_awready) check_eq("wr_accept", {31'b0, axi_awready}, 32'd1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    n = 0;
    while (!axi_bvalid && n < LIM) begin
      @(negedge clk); n++;
    end
    if (!axi_bvalid) check_eq("wr_bvalid", {31'b0, axi_bvalid}, 32'd1);
    resp = axi_bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk);
    axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b1;
    #1;
    n = 0;
    while (!axi_arready && n < LIM) begin
      @(negedge clk); #1; n++;
    end
    if (!axi_arready) check_eq("rd_accept", {31'b0, axi_arready}, 32'd1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    n = 0;
    while (!axi_rvalid && n < LIM) begin
      @(negedge clk); n++;
    end
    rd_wait = n;
    if (!axi_rvalid) check_eq("rd_rvalid", {31'b0, axi_rvalid}, 32'd1);
    d = axi_rdata;
    resp = axi_rresp;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1. reset state and all six registers read 0 ----
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {27'b0, axi_bvalid, axi_rvalid, axi_awready, axi_arready, irq}, 32'h0);
    check_eq("rst_oe", 32'(gpio_oe), 32'h0);
    check_eq("rst_out", 32'(gpio_out), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      axi_read(BASE + 32'(4 * i), rd, rsp);
      check_eq($sformatf("rst_rd_%0d", i), rd, 32'h0);
      check_eq($sformatf("rst_rresp_%0d", i), 32'(rsp), 32'h0);
    end
    check_eq("rd_latency", 32'(rd_wait), 32'h0);

    // ---- 2. direction, data out, byte strobes, unused upper bits ----
    axi_write(BASE + 32'h04, 32'h0000_00FF, 4'b1111, rsp);
    check_eq("dir_bresp", 32'(rsp), 32'h0);
    axi_write(BASE + 32'h00, 32'h0000_00A5, 4'b0001, rsp);
    check_eq("oe_ff", 32'(gpio_oe), 32'hFF);
    check_eq("out_a5", 32'(gpio_out), 32'hA5);
    axi_write(BASE + 32'h00, 32'h0000_005A, 4'b0010, rsp);
    check_eq("out_strb_masked", 32'(gpio_out), 32'hA5);
    axi_write(BASE + 32'h00, 32'hFFFF_FF3C, 4'b1111, rsp);
    axi_read(BASE + 32'h00, rd, rsp);
    check_eq("out_upper_zero", rd, 32'h0000_003C);
    check_eq("out_3c", 32'(gpio_out), 32'h3C);

    // ---- 3. rising edge on pin 0, irq timing, W1C ----
    axi_write(BASE + 32'h0C, 32'h01, 4'b1111, rsp);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (S) @(negedge clk);
    check_eq("stat_before_sync", dut.r_irq_stat, 32'h0);
    @(negedge clk);
    check_eq("stat_at_s1", dut.r_irq_stat, 32'h01);
    check_eq("irq_at_s1", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check_eq("irq_at_s2", {31'b0, irq}, 32'h1);
    axi_read(BASE + 32'h08, rd, rsp);
    check_eq("data_in_p0", rd, 32'h01);
    axi_write(BASE + 32'h10, 32'h01, 4'b1111, rsp);
    check_eq("irq_after_w1c", {31'b0, irq}, 32'h0);
    axi_read(BASE + 32'h10, rd, rsp);
    check_eq("stat_after_w1c", rd, 32'h0);

    // ---- 4. falling-edge select on pin 1, W1C collision ----
    axi_write(BASE + 32'h14, 32'h02, 4'b1111, rsp);
    @(negedge clk);
    gpio_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    axi_read(BASE + 32'h10, rd, rsp);
    check_eq("stat_no_rise", rd, 32'h0);
    @(negedge clk);
    gpio_in[1] = 1'b0;
    repeat (6) @(negedge clk);
    axi_read(BASE + 32'h10, rd, rsp);
    check_eq("stat_fall", rd, 32'h02);
    check_eq("irq_bit1_masked", {31'b0, irq}, 32'h0);
    @(negedge clk);
    gpio_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    gpio_in[1] = 1'b0;
    // Edge pulse is live between clock edge S and S+1; the W1C is accepted on S+1.
    repeat (S) @(negedge clk);
    axi_awaddr = BASE + 32'h10; axi_wdata = 32'h02; axi_wstrb = 4'b1111;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    #1;
    check_eq("collide_accept", {31'b0, axi_awready}, 32'h1);
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(posedge clk); #1;
    axi_read(BASE + 32'h10, rd, rsp);
    check_eq("stat_set_wins", rd, 32'h02);
    axi_write(BASE + 32'h10, 32'h02, 4'b1111, rsp);
    axi_read(BASE + 32'h10, rd, rsp);
    check_eq("stat_cleared", rd, 32'h0);

    // ---- 5. error responses ----
    axi_write(BASE + 32'h08, 32'hFF, 4'b1111, rsp);
    check_eq("wr_ro_bresp", 32'(rsp), 32'h2);
    axi_read(BASE + 32'h08, rd, rsp);
    check_eq("data_in_kept", rd, 32'h01);
    axi_read(BASE + 32'h1C, rd, rsp);
    check_eq("rd_oob_rresp", 32'(rsp), 32'h2);
    check_eq("rd_oob_rdata", rd, 32'h0);
    axi_read(BASE + 32'h01, rd, rsp);
    check_eq("rd_misalign_rresp", 32'(rsp), 32'h2);
    axi_read(BASE - 32'h04, rd, rsp);
    check_eq("rd_below_base", {30'b0, rsp}, 32'h2);
    axi_write(BASE + 32'h18, 32'h00, 4'b1111, rsp);
    check_eq("wr_oob_bresp", 32'(rsp), 32'h2);
    check_eq("wr_oob_no_change", 32'(gpio_oe), 32'hFF);

    // ---- 6. backpressure, no second accept, read snapshot ----
    @(negedge clk);
    axi_bready = 1'b0; axi_rready = 1'b0;
    axi_awaddr = BASE + 32'h00; axi_wdata = 32'h11; axi_wstrb = 4'b1111;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_araddr = BASE + 32'h00; axi_arvalid = 1'b1;
    #1;
    check_eq("bp_first_accept", {30'b0, axi_awready, axi_arready}, 32'h3);
    @(posedge clk); #1;
    axi_wdata = 32'h22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      // {bvalid, rvalid, awready, wready, arready, bresp}
      check_eq($sformatf("bp_hs_%0d", i),
               {25'b0, axi_bvalid, axi_rvalid, axi_awready, axi_wready, axi_arready, axi_bresp},
               32'b110_0000);
      check_eq($sformatf("bp_rdata_%0d", i), axi_rdata, 32'h3C);
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    axi_bready = 1'b1; axi_rready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_released", {30'b0, axi_bvalid, axi_rvalid}, 32'h0);
    axi_read(BASE + 32'h00, rd, rsp);
    check_eq("bp_single_write", rd, 32'h11);

    // ---- reset in the middle of pending responses ----
    @(negedge clk);
    axi_bready = 1'b0; axi_rready = 1'b0;
    axi_awaddr = BASE + 32'h04; axi_wdata = 32'h0F; axi_wstrb = 4'b1111;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_araddr = BASE + 32'h04; axi_arvalid = 1'b1;
    @(posedge clk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    check_eq("pend_valids", {30'b0, axi_bvalid, axi_rvalid}, 32'h3);
    #2;
    rst_n = 1'b0;
    gpio_in = '0;
    #1;
    check_eq("arst_valids", {30'b0, axi_bvalid, axi_rvalid}, 32'h0);
    check_eq("arst_pads", {16'b0, gpio_oe, gpio_out}, 32'h0);
    check_eq("arst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(BASE + 32'h04, rd, rsp);
    check_eq("post_rst_dir", rd, 32'h0);
    axi_read(BASE + 32'h10, rd, rsp);
    check_eq("post_rst_stat", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
